// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller.
//   LT_*     : two-bit lamp encodings driven onto mainLight / sideLight
//   state_t  : controller phase, one code per phase of the cycle
package traffic_pkg;

  localparam logic [1:0] LT_RED = 2'b00;
  localparam logic [1:0] LT_YEL = 2'b01;
  localparam logic [1:0] LT_GRN = 2'b10;
  localparam logic [1:0] LT_OFF = 2'b11;

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_X = 3'd1,
    MAIN_Y = 3'd2,
    WALK   = 3'd3,
    SIDE_G = 3'd4,
    SIDE_X = 3'd5,
    SIDE_Y = 3'd6,
    NIGHT  = 3'd7
  } state_t;

endpackage

// File: rtl/tick_gen.sv
// Tick prescaler: pulses tick for one clk on the terminal count of a
// 0..TICK_CYCLES-1 counter.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : restart the count (phase entry), so every phase is an exact
//          whole number of ticks long
//   tick : one-cycle pulse every TICK_CYCLES cycles
module tick_gen #(
  parameter int TICK_CYCLES = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)        r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + 1'b1;
  end

  // With TICK_CYCLES == 1 the counter sits at 0 and tick is always high.
  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/traffic_light_param.sv
// Intersection controller: main road, side road and pedestrian crossing,
// with sensor-driven green extension, latched walk requests and a
// flashing night mode.
//   clk, rst   : system clock, synchronous active-high reset
//   Sensor     : side-road vehicle present (level)
//   walkButton : pedestrian request (any-length pulse)
//   nightMode  : request flashing night operation (level)
//   walkLight  : walk lamp
//   mainLight  : main lamp (00 red, 01 yellow, 10 green, 11 off)
//   sideLight  : side lamp, same encoding
//   timeLeft   : ticks remaining in the current phase (0 in NIGHT)
module traffic_light_param
  import traffic_pkg::*;
#(
  parameter int TICK_CYCLES = 100000000,
  parameter int T_MAIN      = 6,
  parameter int T_SIDE      = 3,
  parameter int T_EXT       = 3,
  parameter int T_YEL       = 2,
  parameter int T_WALK      = 3,
  parameter int TW          = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Sensor,
  input  logic          walkButton,
  input  logic          nightMode,
  output logic          walkLight,
  output logic [1:0]    mainLight,
  output logic [1:0]    sideLight,
  output logic [TW-1:0] timeLeft
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_time;
  logic          r_walk_req;
  logic          r_sensor_seen;
  logic          r_flash;
  logic          w_tick;
  logic          w_end;
  logic          w_enter;
  logic          w_sensor;
  logic          w_in_green;

  function automatic logic [TW-1:0] dur(input state_t s);
    case (s)
      MAIN_G:         dur = TW'(T_MAIN);
      MAIN_X, SIDE_X: dur = TW'(T_EXT);
      MAIN_Y, SIDE_Y: dur = TW'(T_YEL);
      WALK:           dur = TW'(T_WALK);
      SIDE_G:         dur = TW'(T_SIDE);
      default:        dur = '0;
    endcase
  endfunction

  tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_enter),
    .tick (w_tick)
  );

  assign w_in_green = (r_state == MAIN_G) || (r_state == SIDE_G);
  // A sensor hit on the last green cycle must still earn the extension,
  // so the decision looks at the live input as well as the latch.
  assign w_sensor   = r_sensor_seen || Sensor;
  assign w_end      = w_tick && (r_time == TW'(1)) && (r_state != NIGHT);
  assign w_enter    = (w_state_nxt != r_state);

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MAIN_G: if (w_end) w_state_nxt = w_sensor ? MAIN_X : MAIN_Y;
      MAIN_X: if (w_end) w_state_nxt = MAIN_Y;
      MAIN_Y: if (w_end) w_state_nxt = nightMode  ? NIGHT :
                                        r_walk_req ? WALK  : SIDE_G;
      WALK:   if (w_end) w_state_nxt = SIDE_G;
      SIDE_G: if (w_end) w_state_nxt = w_sensor ? SIDE_X : SIDE_Y;
      SIDE_X: if (w_end) w_state_nxt = SIDE_Y;
      SIDE_Y: if (w_end) w_state_nxt = nightMode ? NIGHT : MAIN_G;
      NIGHT:  if (w_tick && !nightMode) w_state_nxt = MAIN_G;
      default: w_state_nxt = MAIN_G;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= MAIN_G;
      r_time        <= TW'(T_MAIN);
      r_walk_req    <= 1'b0;
      r_sensor_seen <= 1'b0;
      r_flash       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_enter)                         r_time <= dur(w_state_nxt);
      else if (w_tick && r_state != NIGHT) r_time <= r_time - 1'b1;

      if (w_enter && (w_state_nxt == MAIN_G || w_state_nxt == SIDE_G))
        r_sensor_seen <= 1'b0;
      else if (w_in_green && Sensor)
        r_sensor_seen <= 1'b1;

      // Clear on WALK entry beats a same-cycle press.
      if (w_enter && w_state_nxt == WALK)
        r_walk_req <= 1'b0;
      else if (r_state != WALK && walkButton)
        r_walk_req <= 1'b1;

      if (w_enter && w_state_nxt == NIGHT)
        r_flash <= 1'b0;
      else if (r_state == NIGHT && w_tick && nightMode)
        r_flash <= ~r_flash;
    end
  end

  // Moore output decode
  always_comb begin
    mainLight = LT_RED;
    sideLight = LT_RED;
    walkLight = 1'b0;
    case (r_state)
      MAIN_G, MAIN_X: mainLight = LT_GRN;
      MAIN_Y:         mainLight = LT_YEL;
      WALK:           walkLight = 1'b1;
      SIDE_G, SIDE_X: sideLight = LT_GRN;
      SIDE_Y:         sideLight = LT_YEL;
      NIGHT: begin
        mainLight = r_flash ? LT_OFF : LT_YEL;
        sideLight = r_flash ? LT_OFF : LT_RED;
      end
      default: ;
    endcase
  end

  assign timeLeft = r_time;

endmodule

// File: tb/tb_traffic_light_param.sv
module tb_traffic_light_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       Sensor, walkButton, nightMode;
  logic       walkLight;
  logic [1:0] mainLight, sideLight;
  logic [3:0] timeLeft;

  traffic_light_param #(.TICK_CYCLES(4), .TW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .Sensor     (Sensor),
    .walkButton (walkButton),
    .nightMode  (nightMode),
    .walkLight  (walkLight),
    .mainLight  (mainLight),
    .sideLight  (sideLight),
    .timeLeft   (timeLeft)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         do_rst;
    bit         sen, wb, nm;
    int         hold;
    logic [1:0] m, s;
    logic       wl;
    logic [3:0] tl;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   inv_chk  = 0;
  int   inv_fail = 0;
  bit   mon_en   = 1'b0;

  function automatic void add(string nm_, bit r, bit se, bit w, bit ni, int h,
                              logic [1:0] m, logic [1:0] s, logic wl, logic [3:0] tl);
    vec_t v;
    v.name = nm_; v.do_rst = r; v.sen = se; v.wb = w; v.nm = ni; v.hold = h;
    v.m = m; v.s = s; v.wl = wl; v.tl = tl;
    vq.push_back(v);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic chk(input string nm_, input logic [1:0] m, input logic [1:0] s,
                     input logic wl, input logic [3:0] tl);
    logic [8:0] act, exp;
    act = {mainLight, sideLight, walkLight, timeLeft};
    exp = {m, s, wl, tl};
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got main=%b side=%b walk=%b tl=%0d, want main=%b side=%b walk=%b tl=%0d",
               nm_, mainLight, sideLight, walkLight, timeLeft, m, s, wl, tl);
    end
  endtask

  // Every cycle: lamps never conflict outside the night pattern, walk only
  // with both roads red, and timeLeft is 0 only in the night pattern.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      inv_chk++;
      if ((mainLight != 2'b00 && sideLight != 2'b00 &&
           !(mainLight == 2'b11 && sideLight == 2'b11)) ||
          (walkLight && (mainLight != 2'b00 || sideLight != 2'b00)) ||
          (timeLeft == 4'd0 && !((mainLight == 2'b01 && sideLight == 2'b00) ||
                                 (mainLight == 2'b11 && sideLight == 2'b11)))) begin
        inv_fail++;
        $display("invariant broken at %0t: main=%b side=%b walk=%b tl=%0d",
                 $time, mainLight, sideLight, walkLight, timeLeft);
      end
    end
  end

  initial begin
    rst = 1'b1; Sensor = 1'b0; walkButton = 1'b0; nightMode = 1'b0;

    // Idle cycle: 24 / 8 / 12 / 8 cycles, period 52
    add("idle_rst",    1,0,0,0, 0, 2'b10,2'b00,0,4'd6);
    add("idle_mg5",    0,0,0,0, 4, 2'b10,2'b00,0,4'd5);
    add("idle_mg_end", 0,0,0,0,19, 2'b10,2'b00,0,4'd1);
    add("idle_my",     0,0,0,0, 1, 2'b01,2'b00,0,4'd2);
    add("idle_my_end", 0,0,0,0, 7, 2'b01,2'b00,0,4'd1);
    add("idle_sg",     0,0,0,0, 1, 2'b00,2'b10,0,4'd3);
    add("idle_sg_end", 0,0,0,0,11, 2'b00,2'b10,0,4'd1);
    add("idle_sy",     0,0,0,0, 1, 2'b00,2'b01,0,4'd2);
    add("idle_wrap",   0,0,0,0, 8, 2'b10,2'b00,0,4'd6);
    // Sensor held: both greens extended
    add("sen_rst",     1,1,0,0, 0, 2'b10,2'b00,0,4'd6);
    add("sen_mg_end",  0,1,0,0,23, 2'b10,2'b00,0,4'd1);
    add("sen_mx",      0,1,0,0, 1, 2'b10,2'b00,0,4'd3);
    add("sen_mx_end",  0,1,0,0,11, 2'b10,2'b00,0,4'd1);
    add("sen_my",      0,1,0,0, 1, 2'b01,2'b00,0,4'd2);
    add("sen_sg",      0,1,0,0, 8, 2'b00,2'b10,0,4'd3);
    add("sen_sg_end",  0,1,0,0,11, 2'b00,2'b10,0,4'd1);
    add("sen_sx",      0,1,0,0, 1, 2'b00,2'b10,0,4'd3);
    add("sen_sy",      0,1,0,0,12, 2'b00,2'b01,0,4'd2);
    add("sen_wrap",    0,1,0,0, 8, 2'b10,2'b00,0,4'd6);
    // Sensor only on the last MAIN_G cycle; side green not extended
    add("pul_rst",     1,0,0,0, 0, 2'b10,2'b00,0,4'd6);
    add("pul_mg_end",  0,0,0,0,23, 2'b10,2'b00,0,4'd1);
    add("pul_mx",      0,1,0,0, 1, 2'b10,2'b00,0,4'd3);
    add("pul_my",      0,0,0,0,12, 2'b01,2'b00,0,4'd2);
    add("pul_sg",      0,0,0,0, 8, 2'b00,2'b10,0,4'd3);
    add("pul_sy",      0,0,0,0,12, 2'b00,2'b01,0,4'd2);
    // Walk request, press during WALK discarded
    add("wlk_rst",     1,0,0,0, 0, 2'b10,2'b00,0,4'd6);
    add("wlk_press",   0,0,1,0, 1, 2'b10,2'b00,0,4'd6);
    add("wlk_my",      0,0,0,0,23, 2'b01,2'b00,0,4'd2);
    add("wlk_walk",    0,0,0,0, 8, 2'b00,2'b00,1,4'd3);
    add("wlk_walk_end",0,0,0,0,11, 2'b00,2'b00,1,4'd1);
    add("wlk_sg",      0,0,1,0, 1, 2'b00,2'b10,0,4'd3);
    add("wlk_no_again",0,0,0,0,52, 2'b00,2'b10,0,4'd3);
    // Night mode raised in SIDE_G, walk press during NIGHT
    add("nt_rst",      1,0,0,0, 0, 2'b10,2'b00,0,4'd6);
    add("nt_sg",       0,0,0,0,34, 2'b00,2'b10,0,4'd3);
    add("nt_sy",       0,0,0,1,10, 2'b00,2'b01,0,4'd2);
    add("nt_sy_end",   0,0,0,1, 7, 2'b00,2'b01,0,4'd1);
    add("nt_enter",    0,0,0,1, 1, 2'b01,2'b00,0,4'd0);
    add("nt_flash",    0,0,0,1, 4, 2'b11,2'b11,0,4'd0);
    add("nt_flash_end",0,0,0,1, 3, 2'b11,2'b11,0,4'd0);
    add("nt_unflash",  0,0,0,1, 1, 2'b01,2'b00,0,4'd0);
    add("nt_press",    0,0,1,1, 1, 2'b01,2'b00,0,4'd0);
    add("nt_hold",     0,0,0,0, 2, 2'b01,2'b00,0,4'd0);
    add("nt_exit",     0,0,0,0, 1, 2'b10,2'b00,0,4'd6);
    add("nt_my",       0,0,0,0,24, 2'b01,2'b00,0,4'd2);
    add("nt_walk",     0,0,0,0, 8, 2'b00,2'b00,1,4'd3);

    foreach (vq[i]) begin
      Sensor = vq[i].sen; walkButton = vq[i].wb; nightMode = vq[i].nm;
      if (vq[i].do_rst) do_reset();
      step(vq[i].hold);
      chk(vq[i].name, vq[i].m, vq[i].s, vq[i].wl, vq[i].tl);
    end

    // Reset in the middle of WALK with a press during reset: request dropped
    Sensor = 0; walkButton = 0; nightMode = 0;
    do_reset();
    walkButton = 1'b1;
    step(1);
    walkButton = 1'b0;
    step(33);
    chk("rw_walk", 2'b00, 2'b00, 1'b1, 4'd3);
    walkButton = 1'b1;
    do_reset();
    chk("rw_after_rst", 2'b10, 2'b00, 1'b0, 4'd6);
    walkButton = 1'b0;
    step(32);
    chk("rw_no_walk", 2'b00, 2'b10, 1'b0, 4'd3);

    n_chk++;
    if (inv_fail != 0) begin
      n_fail++;
      $display("FAIL invariant: %0d bad cycles of %0d, want 0", inv_fail, inv_chk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
